// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: a small FIFO of branch requests feeding a single output
// register that carries the resolved direction, mispredict flag and a saturating mispredict count.
module branch_resolve_unit #(
    parameter int DATA_W = 16,
    parameter int ROB_W  = 4,
    parameter int DEPTH  = 4,
    parameter int JS_MSB = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        opcode,
    input  logic [ROB_W-1:0]  in_index,
    input  logic [DATA_W-1:0] vt,
    input  logic [DATA_W-1:0] va,
    input  logic              pred_taken,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROB_W-1:0]  rob_index,
    output logic [DATA_W-1:0] branch_target,
    output logic              branch_taken,
    output logic              mispredict,
    output logic [15:0]       mispredict_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = ROB_W + 2*DATA_W + 5;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_JNZ = 4'b1001;
    localparam logic [3:0] OP_JS  = 4'b1010;
    localparam logic [3:0] OP_JNS = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;

    // Handshake: a transfer happens on an edge where valid && ready; the producer
    // holds its payload stable while valid is high and ready is low.
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    logic              r_out_valid;
    logic [ROB_W-1:0]  r_rob_index;
    logic [DATA_W-1:0] r_branch_target;
    logic              r_branch_taken;
    logic              r_mispredict;
    logic [15:0]       r_mispredict_count;

    logic              w_push;
    logic              w_pop;
    logic              w_out_fire;
    logic [ENTRY_W-1:0] w_head;
    logic [3:0]        w_head_op;
    logic [ROB_W-1:0]  w_head_idx;
    logic [DATA_W-1:0] w_head_vt;
    logic [DATA_W-1:0] w_head_va;
    logic              w_head_pred;
    logic              w_sign;
    logic              w_taken;

    assign in_ready   = (r_count < CNT_FULL);
    assign w_out_fire = r_out_valid && out_ready;
    assign w_push     = in_valid && in_ready && !flush && !reset;
    assign w_pop      = (r_count != '0) && (!r_out_valid || out_ready) && !flush && !reset;

    // Entry layout, MSB first: opcode, tag, target, operand, prediction.
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_op   = w_head[ENTRY_W-1 -: 4];
    assign w_head_idx  = w_head[ENTRY_W-5 -: ROB_W];
    assign w_head_vt   = w_head[2*DATA_W:DATA_W+1];
    assign w_head_va   = w_head[DATA_W:1];
    assign w_head_pred = w_head[0];

    assign w_sign = (JS_MSB != 0) ? w_head_va[DATA_W-1] : w_head_va[0];

    always_comb begin
        w_taken = 1'b0;
        case (w_head_op)
            OP_JZ:   w_taken = (w_head_va == '0);
            OP_JNZ:  w_taken = (w_head_va != '0);
            OP_JS:   w_taken = w_sign;
            OP_JNS:  w_taken = !w_sign;
            OP_JMP:  w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {opcode, in_index, vt, va, pred_taken};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid        <= 1'b0;
            r_rob_index        <= '0;
            r_branch_target    <= '0;
            r_branch_taken     <= 1'b0;
            r_mispredict       <= 1'b0;
            r_mispredict_count <= '0;
        end else if (flush) begin
            // Flush discards the result in flight but keeps the statistic.
            r_out_valid <= 1'b0;
        end else begin
            if (w_pop) begin
                r_out_valid     <= 1'b1;
                r_rob_index     <= w_head_idx;
                r_branch_target <= w_head_vt;
                r_branch_taken  <= w_taken;
                r_mispredict    <= w_taken ^ w_head_pred;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            if (w_out_fire && r_mispredict && (r_mispredict_count != 16'hFFFF)) begin
                r_mispredict_count <= r_mispredict_count + 16'd1;
            end
        end
    end

    assign out_valid        = r_out_valid;
    assign rob_index        = r_rob_index;
    assign branch_target    = r_branch_target;
    assign branch_taken     = r_branch_taken;
    assign mispredict       = r_mispredict;
    assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; a second instance with JS_MSB=1
// shares all inputs so both sign-test modes are observed from one stimulus stream.
module tb_branch_resolve_unit;

  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_JNZ = 4'b1001;
  localparam logic [3:0] OP_JS  = 4'b1010;
  localparam logic [3:0] OP_JNS = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, pred_taken, out_ready;
  logic [3:0]  opcode, in_index;
  logic [15:0] vt, va;
  logic        in_ready, out_valid, branch_taken, mispredict;
  logic [3:0]  rob_index;
  logic [15:0] branch_target, mispredict_count;
  logic        b_in_ready, b_out_valid, b_branch_taken, b_mispredict;
  logic [3:0]  b_rob_index;
  logic [15:0] b_branch_target, b_mispredict_count;

  int errors = 0;
  int checks = 0;

  branch_resolve_unit #(.DATA_W(16), .ROB_W(4), .DEPTH(4), .JS_MSB(0)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .in_index(in_index), .vt(vt), .va(va), .pred_taken(pred_taken),
    .out_valid(out_valid), .out_ready(out_ready), .rob_index(rob_index),
    .branch_target(branch_target), .branch_taken(branch_taken), .mispredict(mispredict),
    .mispredict_count(mispredict_count)
  );

  branch_resolve_unit #(.DATA_W(16), .ROB_W(4), .DEPTH(4), .JS_MSB(1)) dut_msb (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .opcode(opcode), .in_index(in_index), .vt(vt), .va(va), .pred_taken(pred_taken),
    .out_valid(b_out_valid), .out_ready(out_ready), .rob_index(b_rob_index),
    .branch_target(b_branch_target), .branch_taken(b_branch_taken), .mispredict(b_mispredict),
    .mispredict_count(b_mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic drive_req(input logic [3:0] op, input logic [3:0] idx,
                           input logic [15:0] t, input logic [15:0] a, input logic p);
    in_valid = 1'b1; opcode = op; in_index = idx; vt = t; va = a; pred_taken = p;
  endtask

  task automatic idle();
    in_valid = 1'b0; opcode = 4'h0; in_index = 4'h0; vt = 16'h0; va = 16'h0; pred_taken = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (rob_index !== 4'h0) begin errors++; $display("FAIL reset_rob_index got=%0h exp=0", rob_index); end
    checks++; if (branch_target !== 16'h0) begin errors++; $display("FAIL reset_target got=%0h exp=0", branch_target); end
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got=%0b exp=0", branch_taken); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict got=%0b exp=0", mispredict); end
    checks++; if (mispredict_count !== 16'h0) begin errors++; $display("FAIL reset_mcount got=%0h exp=0", mispredict_count); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_b_in_ready got=%0b exp=1", b_in_ready); end
    checks++; if (b_mispredict_count !== 16'h0) begin errors++; $display("FAIL reset_b_mcount got=%0h exp=0", b_mispredict_count); end
    reset = 1'b0;
  endtask

  task automatic test_single_jz();
    @(negedge clk);
    out_ready = 1'b1;
    drive_req(OP_JZ, 4'd3, 16'h0040, 16'h0000, 1'b0);
    @(negedge clk);
    idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL jz_early_valid got=%0b exp=0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL jz_valid got=%0b exp=1", out_valid); end
    checks++; if (rob_index !== 4'd3) begin errors++; $display("FAIL jz_rob_index got=%0h exp=3", rob_index); end
    checks++; if (branch_target !== 16'h0040) begin errors++; $display("FAIL jz_target got=%0h exp=0040", branch_target); end
    checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL jz_taken got=%0b exp=1", branch_taken); end
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL jz_mispredict got=%0b exp=1", mispredict); end
    checks++; if (mispredict_count !== 16'd0) begin errors++; $display("FAIL jz_mcount_before got=%0d exp=0", mispredict_count); end
    @(negedge clk);
    checks++; if (mispredict_count !== 16'd1) begin errors++; $display("FAIL jz_mcount_after got=%0d exp=1", mispredict_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL jz_drop_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [15:0] bp_va [5];
    logic        exp_taken [5];
    bp_va = '{16'h0000, 16'h0005, 16'h0000, 16'h0001, 16'hFFFF};
    exp_taken = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_push%0d got=%0b exp=1", i, in_ready); end
      drive_req(OP_JNZ, 4'(i), 16'h0100 + 16'(i), bp_va[i], 1'b1);
    end
    @(negedge clk);
    idle();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_held_valid got=%0b exp=1", out_valid); end
    @(negedge clk);
    checks++; if (rob_index !== 4'd0) begin errors++; $display("FAIL bp_hold_rob got=%0h exp=0", rob_index); end
    checks++; if (branch_target !== 16'h0100) begin errors++; $display("FAIL bp_hold_target got=%0h exp=0100", branch_target); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid%0d got=%0b exp=1", i, out_valid); end
      checks++; if (rob_index !== 4'(i)) begin errors++; $display("FAIL bp_drain_rob%0d got=%0h exp=%0h", i, rob_index, i); end
      checks++; if (branch_taken !== exp_taken[i]) begin errors++; $display("FAIL bp_drain_taken%0d got=%0b exp=%0b", i, branch_taken, exp_taken[i]); end
      checks++; if (mispredict !== !exp_taken[i]) begin errors++; $display("FAIL bp_drain_mis%0d got=%0b exp=%0b", i, mispredict, !exp_taken[i]); end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty_valid got=%0b exp=0", out_valid); end
    checks++; if (mispredict_count !== 16'd3) begin errors++; $display("FAIL bp_mcount got=%0d exp=3", mispredict_count); end
  endtask

  task automatic test_back_to_back_js();
    logic [3:0]  s_op [4];
    logic [3:0]  s_idx [4];
    logic [15:0] s_va [4];
    logic        s_pred [4];
    logic        s_t0 [4];
    logic        s_t1 [4];
    s_op   = '{OP_JS, OP_JNS, 4'b0011, OP_JMP};
    s_idx  = '{4'd5, 4'd6, 4'd7, 4'd9};
    s_va   = '{16'h8000, 16'h8000, 16'h0000, 16'h1234};
    s_pred = '{1'b0, 1'b0, 1'b1, 1'b1};
    s_t0   = '{1'b0, 1'b1, 1'b0, 1'b1};
    s_t1   = '{1'b1, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        int j;
        j = k - 2;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d got=%0b exp=1", j, out_valid); end
        checks++; if (rob_index !== s_idx[j]) begin errors++; $display("FAIL b2b_rob%0d got=%0h exp=%0h", j, rob_index, s_idx[j]); end
        checks++; if (branch_target !== 16'h0200 + 16'(s_idx[j])) begin errors++; $display("FAIL b2b_target%0d got=%0h exp=%0h", j, branch_target, 16'h0200 + 16'(s_idx[j])); end
        checks++; if (branch_taken !== s_t0[j]) begin errors++; $display("FAIL b2b_taken_lsb%0d got=%0b exp=%0b", j, branch_taken, s_t0[j]); end
        checks++; if (mispredict !== (s_t0[j] ^ s_pred[j])) begin errors++; $display("FAIL b2b_mis_lsb%0d got=%0b exp=%0b", j, mispredict, s_t0[j] ^ s_pred[j]); end
        checks++; if (b_out_valid !== 1'b1 || b_rob_index !== s_idx[j] || b_branch_target !== 16'h0200 + 16'(s_idx[j])) begin
          errors++; $display("FAIL b2b_msb_tag%0d got=%0b/%0h/%0h exp=1/%0h", j, b_out_valid, b_rob_index, b_branch_target, s_idx[j]);
        end
        checks++; if (b_branch_taken !== s_t1[j]) begin errors++; $display("FAIL b2b_taken_msb%0d got=%0b exp=%0b", j, b_branch_taken, s_t1[j]); end
        checks++; if (b_mispredict !== (s_t1[j] ^ s_pred[j])) begin errors++; $display("FAIL b2b_mis_msb%0d got=%0b exp=%0b", j, b_mispredict, s_t1[j] ^ s_pred[j]); end
      end
      if (k < 4) drive_req(s_op[k], s_idx[k], 16'h0200 + 16'(s_idx[k]), s_va[k], s_pred[k]);
      else idle();
    end
    checks++; if (mispredict_count !== 16'd5) begin errors++; $display("FAIL b2b_mcount got=%0d exp=5", mispredict_count); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_req(OP_JMP, 4'(8 + i), 16'h0400, 16'h0000, 1'b0);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || rob_index !== 4'd8) begin errors++; $display("FAIL flush_pre got=%0b/%0h exp=1/8", out_valid, rob_index); end
    flush = 1'b1; out_ready = 1'b1;
    drive_req(OP_JMP, 4'd15, 16'h0500, 16'h0000, 1'b0);
    @(negedge clk);
    flush = 1'b0; idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
    checks++; if (mispredict_count !== 16'd5) begin errors++; $display("FAIL flush_mcount got=%0d exp=5", mispredict_count); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_late_valid%0d got=%0b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_req(OP_JMP, 4'(i), 16'h0600, 16'h0000, 1'b0);
    end
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_full got=%0b exp=0", in_ready); end
    reset = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got=%0b exp=1", in_ready); end
    checks++; if (rob_index !== 4'h0 || branch_target !== 16'h0) begin errors++; $display("FAIL rmid_data got=%0h/%0h exp=0/0", rob_index, branch_target); end
    checks++; if (branch_taken !== 1'b0 || mispredict !== 1'b0) begin errors++; $display("FAIL rmid_flags got=%0b/%0b exp=0/0", branch_taken, mispredict); end
    checks++; if (mispredict_count !== 16'd0) begin errors++; $display("FAIL rmid_mcount got=%0d exp=0", mispredict_count); end
    drive_req(OP_JZ, 4'd2, 16'h0300, 16'h0000, 1'b1);
    @(negedge clk);
    idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_new_early got=%0b exp=0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || rob_index !== 4'd2 || branch_target !== 16'h0300) begin
      errors++; $display("FAIL rmid_new_result got=%0b/%0h/%0h exp=1/2/0300", out_valid, rob_index, branch_target);
    end
    checks++; if (branch_taken !== 1'b1 || mispredict !== 1'b0) begin errors++; $display("FAIL rmid_new_flags got=%0b/%0b exp=1/0", branch_taken, mispredict); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || mispredict_count !== 16'd0) begin errors++; $display("FAIL rmid_after got=%0b/%0d exp=0/0", out_valid, mispredict_count); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    drive_req(OP_JMP, 4'd1, 16'h0700, 16'h0000, 1'b0);
    repeat (100) @(negedge clk);
    checks++; if (mispredict_count !== 16'd98) begin errors++; $display("FAIL sat_partial got=%0d exp=98", mispredict_count); end
    repeat (65436) @(negedge clk);
    checks++; if (mispredict_count !== 16'hFFFE) begin errors++; $display("FAIL sat_near got=%0h exp=fffe", mispredict_count); end
    repeat (4) @(negedge clk);
    checks++; if (mispredict_count !== 16'hFFFF) begin errors++; $display("FAIL sat_cap got=%0h exp=ffff", mispredict_count); end
    idle();
    repeat (3) @(negedge clk);
    checks++; if (mispredict_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%0h exp=ffff", mispredict_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_drain_valid got=%0b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single_jz();
    test_backpressure();
    test_back_to_back_js();
    test_flush();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
